// File: rtl/dlsc_pcie_s6_outbound_write_tlpgen.sv
// Memory Write TLP generator for the 32-bit Spartan-6 PCIe TX stream:
// emits a 3DW/4DW header from a captured descriptor, then passes the payload through.
module dlsc_pcie_s6_outbound_write_tlpgen #(
    parameter int ADDR = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [15:0]     requester_id,
    output logic            wr_tlp_h_ready,
    input  logic            wr_tlp_h_valid,
    input  logic [ADDR-3:0] wr_tlp_h_addr,
    input  logic [9:0]      wr_tlp_h_len,
    input  logic [3:0]      wr_tlp_h_be_first,
    input  logic [3:0]      wr_tlp_h_be_last,
    output logic            wr_tlp_d_ready,
    input  logic            wr_tlp_d_valid,
    input  logic [31:0]     wr_tlp_d_data,
    input  logic            tx_ready,
    output logic            tx_valid,
    output logic [31:0]     tx_data,
    output logic            tx_last,
    output logic            busy
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_H0,
        ST_H1,
        ST_H2,
        ST_HA,
        ST_DATA
    } state_t;

    state_t          state, state_next;
    logic [ADDR-3:0] addr_r;
    logic [9:0]      len_r;
    logic [3:0]      bef_r, bel_r;
    logic [10:0]     rem, rem_next;
    logic            tx_valid_next, tx_last_next;
    logic [31:0]     tx_data_next;
    logic            capture;
    logic            adv;
    logic [63:0]     byte_addr;
    logic            is_4dw;
    logic [31:0]     dw0, dw1;

    assign adv       = !tx_valid || tx_ready;
    assign byte_addr = 64'(addr_r) << 2;
    assign is_4dw    = (byte_addr[63:32] != 32'd0);

    assign dw0 = {1'b0, (is_4dw ? 2'b11 : 2'b10), 5'b00000, 1'b0, 3'b000, 4'b0000,
                  1'b0, 1'b0, 2'b00, 2'b00, len_r};
    assign dw1 = {requester_id, 8'h00, ((len_r == 10'd1) ? 4'h0 : bel_r), bef_r};

    assign wr_tlp_h_ready = (state == ST_IDLE);
    assign wr_tlp_d_ready = (state == ST_DATA) && adv;
    assign busy           = (state != ST_IDLE) || tx_valid;

    always_comb begin
        state_next    = state;
        tx_valid_next = tx_valid;
        tx_data_next  = tx_data;
        tx_last_next  = tx_last;
        rem_next      = rem;
        capture       = 1'b0;

        // Once the held beat is taken, the register empties unless a new DW is loaded below.
        if (adv) begin
            tx_valid_next = 1'b0;
            tx_last_next  = 1'b0;
        end

        case (state)
            ST_IDLE: begin
                if (wr_tlp_h_valid) begin
                    capture    = 1'b1;
                    rem_next   = (wr_tlp_h_len == 10'd0) ? 11'd1024 : {1'b0, wr_tlp_h_len};
                    state_next = ST_H0;
                end
            end
            ST_H0: begin
                if (adv) begin
                    tx_valid_next = 1'b1;
                    tx_data_next  = dw0;
                    state_next    = ST_H1;
                end
            end
            ST_H1: begin
                if (adv) begin
                    tx_valid_next = 1'b1;
                    tx_data_next  = dw1;
                    state_next    = is_4dw ? ST_H2 : ST_HA;
                end
            end
            ST_H2: begin
                if (adv) begin
                    tx_valid_next = 1'b1;
                    tx_data_next  = byte_addr[63:32];
                    state_next    = ST_HA;
                end
            end
            ST_HA: begin
                if (adv) begin
                    tx_valid_next = 1'b1;
                    tx_data_next  = byte_addr[31:0];
                    state_next    = ST_DATA;
                end
            end
            ST_DATA: begin
                if (adv && wr_tlp_d_valid) begin
                    tx_valid_next = 1'b1;
                    tx_data_next  = wr_tlp_d_data;
                    tx_last_next  = (rem == 11'd1);
                    rem_next      = rem - 11'd1;
                    if (rem == 11'd1) begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            tx_valid <= 1'b0;
            tx_data  <= '0;
            tx_last  <= 1'b0;
            rem      <= '0;
            addr_r   <= '0;
            len_r    <= '0;
            bef_r    <= '0;
            bel_r    <= '0;
        end else begin
            state    <= state_next;
            tx_valid <= tx_valid_next;
            tx_data  <= tx_data_next;
            tx_last  <= tx_last_next;
            rem      <= rem_next;
            if (capture) begin
                addr_r <= wr_tlp_h_addr;
                len_r  <= wr_tlp_h_len;
                bef_r  <= wr_tlp_h_be_first;
                bel_r  <= wr_tlp_h_be_last;
            end
        end
    end

endmodule
